// File: rtl/uart_loader_pkg.sv
// Shared definitions for the UART weight loader: FSM states, abort codes, default sync marker.
package uart_loader_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_LEN_LO,
    ST_LEN_HI,
    ST_PAYLOAD,
    ST_CHECK
  } state_t;

  typedef enum logic [1:0] {
    ERR_NONE    = 2'd0,
    ERR_TIMEOUT = 2'd1,
    ERR_LEN     = 2'd2,
    ERR_CHK     = 2'd3
  } err_code_t;

  localparam logic [7:0] DEFAULT_SYNC_BYTE = 8'hA5;

endpackage

// File: rtl/uart_weight_loader_byte_gap_timer.sv
// Inter-byte gap timer: reloads on every received byte, counts down while a frame is open,
// and flags expiry once TIMEOUT_CLKS idle clocks have elapsed.
module byte_gap_timer #(
  parameter int unsigned TIMEOUT_CLKS = 1_000_000
) (
  input  logic clk,
  input  logic rst,
  input  logic restart,
  input  logic run,
  output logic expire_c
);
  localparam int unsigned CNT_W = (TIMEOUT_CLKS < 1) ? 1 : $clog2(TIMEOUT_CLKS + 1);

  logic [CNT_W-1:0] cnt;

  // Reload on each byte, otherwise count down to zero while running
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt <= CNT_W'(TIMEOUT_CLKS);
    end else if (restart) begin
      cnt <= CNT_W'(TIMEOUT_CLKS);
    end else if (run && (cnt != '0)) begin
      cnt <= cnt - CNT_W'(1);
    end
  end

  assign expire_c = run && (cnt == '0);

endmodule

// File: rtl/uart_weight_loader.sv
// Framed weight-upload parser: SYNC, LEN_LO, LEN_HI, N little-endian words, optional CHK.
// Optional feature macro: UART_LOADER_CHECKSUM_EN (adds the trailing checksum byte and CHECK state).
module uart_weight_loader
  import uart_loader_pkg::*;
#(
  parameter int unsigned WORD_BYTES   = 2,
  parameter int unsigned ADDR_WIDTH   = 10,
  parameter logic [7:0]  SYNC_BYTE    = DEFAULT_SYNC_BYTE,
  parameter int unsigned TIMEOUT_CLKS = 1_000_000
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic [7:0]              rx_data,
  input  logic                    rx_ready,
  output logic                    wr_en,
  output logic [ADDR_WIDTH-1:0]   wr_addr,
  output logic [8*WORD_BYTES-1:0] wr_data,
  output logic                    busy,
  output logic                    done,
  output logic                    err,
  output logic [1:0]              err_code,
  output logic                    weights_valid
);
  localparam int unsigned DATA_W    = 8 * WORD_BYTES;
  localparam int unsigned IDX_W     = (WORD_BYTES > 1) ? $clog2(WORD_BYTES) : 1;
  localparam logic [32:0] MAX_WORDS = 33'd1 << ADDR_WIDTH;

  state_t                state, state_nx;
  logic [7:0]            len_lo, len_lo_nx;
  logic [15:0]           words_left, words_left_nx;
  logic [IDX_W-1:0]      byte_idx, byte_idx_nx;
  logic [DATA_W-1:0]     word, word_nx;
  logic [ADDR_WIDTH-1:0] waddr, waddr_nx;
  logic                  wr_en_nx, done_nx, err_nx, valid_nx;
  logic [ADDR_WIDTH-1:0] wr_addr_nx;
  logic [DATA_W-1:0]     wr_data_nx;
  logic [1:0]            err_code_nx;
`ifdef UART_LOADER_CHECKSUM_EN
  logic [7:0]            sum, sum_nx;
`endif

  logic [15:0] len_rx;
  logic        len_bad, len_zero, last_byte, last_word, expire_c;

  assign len_rx    = {rx_data, len_lo};
  assign len_bad   = 33'(len_rx) > MAX_WORDS;
  assign len_zero  = (len_rx == 16'd0);
  assign last_byte = (byte_idx == IDX_W'(WORD_BYTES - 1));
  assign last_word = (words_left == 16'd1);

  byte_gap_timer #(
    .TIMEOUT_CLKS(TIMEOUT_CLKS)
  ) u_gap_timer (
    .clk      (clk),
    .rst      (rst),
    .restart  (rx_ready),
    .run      (state != ST_IDLE),
    .expire_c (expire_c)
  );

  // State register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= ST_IDLE;
    else     state <= state_nx;
  end

  // Next-state logic; a byte arriving with the timeout takes priority
  always_comb begin
    state_nx = state;
    if (rx_ready) begin
      case (state)
        ST_IDLE:   if (rx_data == SYNC_BYTE) state_nx = ST_LEN_LO;
        ST_LEN_LO: state_nx = ST_LEN_HI;
        ST_LEN_HI: begin
          if (len_bad)       state_nx = ST_IDLE;
`ifdef UART_LOADER_CHECKSUM_EN
          else if (len_zero) state_nx = ST_CHECK;
`else
          else if (len_zero) state_nx = ST_IDLE;
`endif
          else               state_nx = ST_PAYLOAD;
        end
        ST_PAYLOAD: begin
`ifdef UART_LOADER_CHECKSUM_EN
          if (last_byte && last_word) state_nx = ST_CHECK;
`else
          if (last_byte && last_word) state_nx = ST_IDLE;
`endif
        end
        default:   state_nx = ST_IDLE;
      endcase
    end else if (expire_c) begin
      state_nx = ST_IDLE;
    end
  end

  // Datapath and output next values
  always_comb begin
    len_lo_nx     = len_lo;
    words_left_nx = words_left;
    byte_idx_nx   = byte_idx;
    word_nx       = word;
    waddr_nx      = waddr;
    wr_en_nx      = 1'b0;
    wr_addr_nx    = wr_addr;
    wr_data_nx    = wr_data;
    done_nx       = 1'b0;
    err_nx        = 1'b0;
    err_code_nx   = err_code;
    valid_nx      = weights_valid;
`ifdef UART_LOADER_CHECKSUM_EN
    sum_nx        = sum;
`endif
    if (rx_ready) begin
      case (state)
        ST_IDLE: begin
          if (rx_data == SYNC_BYTE) begin
            valid_nx    = 1'b0;
            err_code_nx = ERR_NONE;
            waddr_nx    = '0;
            byte_idx_nx = '0;
`ifdef UART_LOADER_CHECKSUM_EN
            sum_nx      = 8'd0;
`endif
          end
        end
        ST_LEN_LO: begin
          len_lo_nx = rx_data;
`ifdef UART_LOADER_CHECKSUM_EN
          sum_nx    = sum + rx_data;
`endif
        end
        ST_LEN_HI: begin
          words_left_nx = len_rx;
          byte_idx_nx   = '0;
`ifdef UART_LOADER_CHECKSUM_EN
          sum_nx        = sum + rx_data;
`endif
          if (len_bad) begin
            err_nx      = 1'b1;
            err_code_nx = ERR_LEN;
          end
`ifndef UART_LOADER_CHECKSUM_EN
          else if (len_zero) begin
            done_nx  = 1'b1;
            valid_nx = 1'b1;
          end
`endif
        end
        ST_PAYLOAD: begin
          for (int unsigned b = 0; b < WORD_BYTES; b++) begin
            if (byte_idx == IDX_W'(b)) word_nx[8*b +: 8] = rx_data;
          end
`ifdef UART_LOADER_CHECKSUM_EN
          sum_nx = sum + rx_data;
`endif
          if (last_byte) begin
            byte_idx_nx   = '0;
            wr_en_nx      = 1'b1;
            wr_addr_nx    = waddr;
            wr_data_nx    = word_nx;
            waddr_nx      = waddr + ADDR_WIDTH'(1);
            words_left_nx = words_left - 16'd1;
`ifndef UART_LOADER_CHECKSUM_EN
            if (last_word) begin
              done_nx  = 1'b1;
              valid_nx = 1'b1;
            end
`endif
          end else begin
            byte_idx_nx = byte_idx + IDX_W'(1);
          end
        end
`ifdef UART_LOADER_CHECKSUM_EN
        ST_CHECK: begin
          if (rx_data == sum) begin
            done_nx  = 1'b1;
            valid_nx = 1'b1;
          end else begin
            err_nx      = 1'b1;
            err_code_nx = ERR_CHK;
          end
        end
`endif
        default: ;
      endcase
    end else if (expire_c) begin
      err_nx      = 1'b1;
      err_code_nx = ERR_TIMEOUT;
    end
  end

  // Registered datapath and outputs
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      len_lo        <= '0;
      words_left    <= '0;
      byte_idx      <= '0;
      word          <= '0;
      waddr         <= '0;
      wr_en         <= 1'b0;
      wr_addr       <= '0;
      wr_data       <= '0;
      busy          <= 1'b0;
      done          <= 1'b0;
      err           <= 1'b0;
      err_code      <= ERR_NONE;
      weights_valid <= 1'b0;
`ifdef UART_LOADER_CHECKSUM_EN
      sum           <= '0;
`endif
    end else begin
      len_lo        <= len_lo_nx;
      words_left    <= words_left_nx;
      byte_idx      <= byte_idx_nx;
      word          <= word_nx;
      waddr         <= waddr_nx;
      wr_en         <= wr_en_nx;
      wr_addr       <= wr_addr_nx;
      wr_data       <= wr_data_nx;
      busy          <= (state_nx != ST_IDLE);
      done          <= done_nx;
      err           <= err_nx;
      err_code      <= err_code_nx;
      weights_valid <= valid_nx;
`ifdef UART_LOADER_CHECKSUM_EN
      sum           <= sum_nx;
`endif
    end
  end

endmodule

// File: tb/tb_uart_weight_loader.sv
// Bench for uart_weight_loader: frame-level reference model checked every cycle,
// directed frames with literal expectations, then randomized frames/stalls/resets.
module tb_uart_weight_loader;
  localparam int unsigned WB   = 2;
  localparam int unsigned AW   = 4;
  localparam int unsigned TO   = 100;
  localparam int          MAXN = 1 << AW;
  localparam logic [7:0]  SYNC = 8'hA5;
`ifdef UART_LOADER_CHECKSUM_EN
  localparam bit CHK_EN = 1'b1;
`else
  localparam bit CHK_EN = 1'b0;
`endif

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic [7:0]    rx_data = 8'h00;
  logic          rx_ready = 1'b0;
  logic          wr_en, busy, done, err, weights_valid;
  logic [AW-1:0] wr_addr;
  logic [15:0]   wr_data;
  logic [1:0]    err_code;

  uart_weight_loader #(
    .WORD_BYTES(WB), .ADDR_WIDTH(AW), .SYNC_BYTE(SYNC), .TIMEOUT_CLKS(TO)
  ) dut (
    .clk(clk), .rst(rst), .rx_data(rx_data), .rx_ready(rx_ready),
    .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data), .busy(busy),
    .done(done), .err(err), .err_code(err_code), .weights_valid(weights_valid)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int passed = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act === exp) passed++;
    else $display("FAIL %s: got 0x%0h want 0x%0h at %0t", name, act, exp, $time);
  endtask

  // Reference model: frame position arithmetic, evaluated once per clock edge
  bit          m_in = 0;
  int          m_pos = 0, m_n = 0, m_gap = 0;
  logic [7:0]  m_lo = 0, m_sum = 0;
  logic [15:0] m_word = 0;
  logic          exp_wr_en = 0, exp_done = 0, exp_err = 0, exp_wv = 0, exp_busy = 0;
  logic [AW-1:0] exp_wr_addr = 0;
  logic [15:0]   exp_wr_data = 0;
  logic [1:0]    exp_ec = 0;

  task automatic m_abort(input logic [1:0] c);
    exp_err = 1'b1; exp_ec = c; m_in = 0;
  endtask

  task automatic m_ok();
    exp_done = 1'b1; exp_wv = 1'b1; m_in = 0;
  endtask

  task automatic model_step(input logic rdy, input logic [7:0] d, input logic r);
    int idx;
    exp_wr_en = 0; exp_done = 0; exp_err = 0;
    if (r) begin
      m_in = 0; m_gap = 0; exp_wr_addr = '0; exp_wr_data = '0; exp_ec = '0; exp_wv = 0;
    end else if (rdy) begin
      m_gap = 0;
      if (!m_in) begin
        if (d == SYNC) begin
          m_in = 1; m_pos = 1; m_sum = 0; exp_wv = 0; exp_ec = 2'd0;
        end
      end else begin
        if (m_pos == 1) begin
          m_lo = d; m_sum = m_sum + d;
        end else if (m_pos == 2) begin
          m_n = int'({d, m_lo}); m_sum = m_sum + d;
          if (m_n > MAXN) m_abort(2'd2);
          else if (m_n == 0 && !CHK_EN) m_ok();
        end else if (m_pos < 3 + m_n * WB) begin
          idx = m_pos - 3;
          m_sum = m_sum + d;
          m_word[8*(idx % WB) +: 8] = d;
          if (idx % WB == WB - 1) begin
            exp_wr_en = 1; exp_wr_addr = AW'(idx / WB); exp_wr_data = m_word;
            if (!CHK_EN && idx == m_n * WB - 1) m_ok();
          end
        end else begin
          if (d == m_sum) m_ok();
          else m_abort(2'd3);
        end
        m_pos++;
      end
    end else if (m_in) begin
      m_gap++;
      if (m_gap > TO) m_abort(2'd1);
    end
    exp_busy = m_in;
  endtask

  // Observation log for directed literal checks
  logic [31:0] wlog[$];
  int n_done = 0, n_err = 0;

  // Compare process: model advances on each edge, outputs checked just after it
  initial begin
    forever begin
      @(posedge clk);
      model_step(rx_ready, rx_data, rst);
      #1;
      check("wr_en",    32'(wr_en),         32'(exp_wr_en));
      check("wr_addr",  32'(wr_addr),       32'(exp_wr_addr));
      check("wr_data",  32'(wr_data),       32'(exp_wr_data));
      check("busy",     32'(busy),          32'(exp_busy));
      check("done",     32'(done),          32'(exp_done));
      check("err",      32'(err),           32'(exp_err));
      check("err_code", 32'(err_code),      32'(exp_ec));
      check("valid",    32'(weights_valid), 32'(exp_wv));
      if (wr_en) wlog.push_back(32'({wr_addr, wr_data}));
      if (done) n_done++;
      if (err) n_err++;
    end
  end

  // Driver helpers; all start and end on a falling edge
  task automatic drive_byte(input logic [7:0] b, input int gap);
    rx_data = b; rx_ready = 1'b1;
    @(negedge clk);
    rx_ready = 1'b0; rx_data = 8'($urandom);
    repeat (gap) @(negedge clk);
  endtask

  task automatic send_frame(input logic [7:0] fr[$], input int gap);
    foreach (fr[i]) drive_byte(fr[i], gap);
  endtask

  task automatic clear_log();
    wlog.delete(); n_done = 0; n_err = 0;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    #1;
    check("rst_wr_en",   32'(wr_en),         32'd0);
    check("rst_wr_addr", 32'(wr_addr),       32'd0);
    check("rst_wr_data", 32'(wr_data),       32'd0);
    check("rst_busy",    32'(busy),          32'd0);
    check("rst_done",    32'(done),          32'd0);
    check("rst_err",     32'(err),           32'd0);
    check("rst_ec",      32'(err_code),      32'd0);
    check("rst_valid",   32'(weights_valid), 32'd0);
    @(negedge clk);
    rst = 1'b0;
  endtask

  logic [7:0] fr[$];
  logic [7:0] fr_ok[$];
  int waited;
  bit found;

  initial begin
    fr_ok = {8'hA5, 8'h02, 8'h00, 8'h34, 8'h12, 8'h78, 8'h56};
    if (CHK_EN) fr_ok.push_back(8'h16);

    repeat (3) @(negedge clk);
    do_reset();
    repeat (2) @(negedge clk);

    // Two-word frame
    clear_log();
    send_frame(fr_ok, 3);
    repeat (2) @(negedge clk);
    check("f1_nwr",   32'(wlog.size()), 32'd2);
    check("f1_w0",    wlog[0], 32'h0_1234);
    check("f1_w1",    wlog[1], 32'h1_5678);
    check("f1_done",  32'(n_done), 32'd1);
    check("f1_valid", 32'(weights_valid), 32'd1);
    check("f1_ec",    32'(err_code), 32'd0);

`ifdef UART_LOADER_CHECKSUM_EN
    // Bad checksum: writes still happen, then checksum error
    clear_log();
    fr = {8'hA5, 8'h02, 8'h00, 8'h34, 8'h12, 8'h78, 8'h56, 8'h17};
    send_frame(fr, 2);
    repeat (2) @(negedge clk);
    check("f2_nwr",   32'(wlog.size()), 32'd2);
    check("f2_err",   32'(n_err), 32'd1);
    check("f2_ec",    32'(err_code), 32'd3);
    check("f2_valid", 32'(weights_valid), 32'd0);
`endif

    // Garbage then single-word frame
    clear_log();
    fr = {8'h00, 8'hFF, 8'h5A, 8'hA5, 8'h01, 8'h00, 8'hCD, 8'hAB};
    if (CHK_EN) fr.push_back(8'h79);
    send_frame(fr, 2);
    repeat (2) @(negedge clk);
    check("f3_nwr",  32'(wlog.size()), 32'd1);
    check("f3_w0",   wlog[0], 32'h0_ABCD);
    check("f3_done", 32'(n_done), 32'd1);

    // Zero-length frame
    clear_log();
    fr = {8'hA5, 8'h00, 8'h00};
    if (CHK_EN) fr.push_back(8'h00);
    send_frame(fr, 2);
    repeat (2) @(negedge clk);
    check("f0_nwr",   32'(wlog.size()), 32'd0);
    check("f0_done",  32'(n_done), 32'd1);
    check("f0_valid", 32'(weights_valid), 32'd1);

    // Length 17 exceeds 16-word memory
    clear_log();
    fr = {8'hA5, 8'h11, 8'h00};
    send_frame(fr, 2);
    repeat (2) @(negedge clk);
    check("len_err",  32'(n_err), 32'd1);
    check("len_ec",   32'(err_code), 32'd2);
    check("len_busy", 32'(busy), 32'd0);
    check("len_nwr",  32'(wlog.size()), 32'd0);

    // Stall after A5 02: err must appear on the 101st edge after the last byte
    clear_log();
    drive_byte(8'hA5, 2);
    drive_byte(8'h02, 0);
    found = 0; waited = 0;
    for (int i = 1; i <= 200 && !found; i++) begin
      @(negedge clk);
      if (err) begin found = 1; waited = i; end
    end
    check("to_latency", 32'(waited), 32'd101);
    check("to_ec",      32'(err_code), 32'd1);
    clear_log();
    send_frame(fr_ok, 2);
    repeat (2) @(negedge clk);
    check("to_next_done", 32'(n_done), 32'd1);

    // Byte arriving on the exact edge the timeout would fire is accepted
    clear_log();
    foreach (fr_ok[i]) drive_byte(fr_ok[i], (i == 4) ? int'(TO) : 2);
    repeat (2) @(negedge clk);
    check("edge_done", 32'(n_done), 32'd1);
    check("edge_err",  32'(n_err), 32'd0);

    // Reset after the third payload byte, then a fresh frame starts at addr 0
    fr = {8'hA5, 8'h02, 8'h00, 8'h34, 8'h12, 8'h78};
    send_frame(fr, 3);
    do_reset();
    clear_log();
    send_frame(fr_ok, 2);
    repeat (2) @(negedge clk);
    check("rst_next_w0",   wlog[0], 32'h0_1234);
    check("rst_next_done", 32'(n_done), 32'd1);

    // Randomized frames, corrupt checksums, oversize lengths, stalls and resets
    for (int f = 0; f < 120; f++) begin
      int n, stall_at, rst_at, gap;
      logic [7:0] s, b;
      fr.delete();
      if ($urandom_range(9) == 0) begin
        fr.push_back(8'($urandom));
        fr.push_back(8'($urandom));
      end
      n = ($urandom_range(9) == 0) ? int'($urandom_range(MAXN + 4, MAXN + 1))
                                   : int'($urandom_range(MAXN, 0));
      fr.push_back(SYNC);
      fr.push_back(8'(n));
      fr.push_back(8'(n >> 8));
      s = 8'(n) + 8'(n >> 8);
      if (n <= MAXN) begin
        for (int i = 0; i < n * WB; i++) begin
          b = 8'($urandom);
          fr.push_back(b);
          s = s + b;
        end
        if (CHK_EN) fr.push_back(($urandom_range(4) == 0) ? (s ^ 8'($urandom_range(255, 1))) : s);
      end
      stall_at = ($urandom_range(19) == 0) ? int'($urandom_range(fr.size() - 1)) : -1;
      rst_at   = ($urandom_range(24) == 0) ? int'($urandom_range(fr.size() - 1, 1)) : -1;
      foreach (fr[i]) begin
        if (i == rst_at) begin
          do_reset();
          break;
        end
        gap = int'($urandom_range(5, 1));
        if (i == stall_at) gap = int'($urandom_range(TO + 5, TO - 2));
        drive_byte(fr[i], gap);
      end
      repeat ($urandom_range(8, 2)) @(negedge clk);
    end

    repeat (TO + 20) @(negedge clk);
    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule
